// File: rtl/evr_event_mapper.sv
// EVR event mapper: looks up each received event code in the mapping RAM and turns the
// mapping word into pulses, timestamp control, heartbeat watchdog and IRQ. Optional: EVR_EVENT_COUNTER_EN.
module evr_event_mapper #(
   parameter int          NUM_PULSE   = 8,
   parameter int          PULSE_WIDTH = 4,
   parameter logic [31:0] HB_TIMEOUT  = 32'd125000000
) (
   input  logic                 CLK_IN,
   input  logic                 RESET_N_IN,
   input  logic                 MAP_EN_IN,
   input  logic [7:0]           EVENT_CODE_IN,
   input  logic                 EVENT_VALID_IN,
   output logic [7:0]           RD_ADDR_OUT,
   input  logic [15:0]          RD_DATA_IN,
   output logic [NUM_PULSE-1:0] PULSE_OUT,
   output logic [31:0]          TS_OUT,
   output logic [31:0]          TS_LATCH_OUT,
   output logic                 TS_LATCH_VALID_OUT,
   output logic                 HB_TIMEOUT_OUT,
   output logic                 IRQ_OUT,
   input  logic                 IRQ_CLR_IN,
   output logic [31:0]          EVENT_CNT_OUT
);

   localparam int             PCW        = $clog2(PULSE_WIDTH + 1);
   localparam logic [PCW-1:0] PCNT_LOAD  = PCW'(PULSE_WIDTH);
   localparam logic [PCW-1:0] PCNT_ONE   = PCW'(1);
   localparam logic [PCW-1:0] PCNT_ZERO  = PCW'(0);

   logic                 accept_s;
   logic                 v1_r;
   logic                 v2_r;
   logic [15:0]          word_s;
   logic                 ts_clr_s;
   logic                 ts_latch_s;
   logic                 irq_set_s;
   logic                 hb_clr_s;
   logic                 unused_word_s;
   logic [PCW-1:0]       pcnt_r     [NUM_PULSE];
   logic [PCW-1:0]       pcnt_nxt_s [NUM_PULSE];
   logic [NUM_PULSE-1:0] pulse_nxt_s;
   logic [31:0]          hb_cnt_r;

   // The null code 0x00 is never looked up; MAP_EN_IN only gates new acceptances.
   assign accept_s = EVENT_VALID_IN & MAP_EN_IN & (EVENT_CODE_IN != 8'h00);

   // The RAM word only means anything while an event sits in S2.
   assign word_s        = v2_r ? RD_DATA_IN : 16'h0000;
   assign ts_latch_s    = word_s[12];
   assign ts_clr_s      = word_s[13];
   assign irq_set_s     = word_s[14];
   assign hb_clr_s      = word_s[15];
   assign unused_word_s = ^word_s;

   // Lookup pipeline: S1 drives the RAM address, S2 marks the returning word.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         RD_ADDR_OUT <= 8'h00;
         v1_r        <= 1'b0;
         v2_r        <= 1'b0;
      end else begin
         if (accept_s) begin
            RD_ADDR_OUT <= EVENT_CODE_IN;
         end
         v1_r <= accept_s;
         v2_r <= v1_r;
      end
   end

   // Pulse stretcher next state; a retrigger reloads so the pulse extends without a gap.
   always_comb begin
      pulse_nxt_s = {NUM_PULSE{1'b0}};
      for (int i = 0; i < NUM_PULSE; i++) begin
         pcnt_nxt_s[i] = PCNT_ZERO;
         if (word_s[i]) begin
            pcnt_nxt_s[i] = PCNT_LOAD;
         end else if (pcnt_r[i] != PCNT_ZERO) begin
            pcnt_nxt_s[i] = pcnt_r[i] - PCNT_ONE;
         end else begin
            pcnt_nxt_s[i] = PCNT_ZERO;
         end
         pulse_nxt_s[i] = (pcnt_nxt_s[i] != PCNT_ZERO);
      end
   end

   // Pulse counters and outputs; the output registers the next count so it rises with the load.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         for (int i = 0; i < NUM_PULSE; i++) begin
            pcnt_r[i] <= PCNT_ZERO;
         end
         PULSE_OUT <= {NUM_PULSE{1'b0}};
      end else begin
         for (int i = 0; i < NUM_PULSE; i++) begin
            pcnt_r[i] <= pcnt_nxt_s[i];
         end
         PULSE_OUT <= pulse_nxt_s;
      end
   end

   // Timestamp counter and latch; the latch sees the pre-reset value when both bits are set.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         TS_OUT             <= 32'h0000_0000;
         TS_LATCH_OUT       <= 32'h0000_0000;
         TS_LATCH_VALID_OUT <= 1'b0;
      end else begin
         TS_OUT             <= ts_clr_s ? 32'h0000_0000 : TS_OUT + 32'h0000_0001;
         TS_LATCH_VALID_OUT <= ts_latch_s;
         if (ts_latch_s) begin
            TS_LATCH_OUT <= TS_OUT;
         end
      end
   end

   // Heartbeat watchdog: saturating counter, flag registered from the current count.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         hb_cnt_r       <= 32'h0000_0000;
         HB_TIMEOUT_OUT <= 1'b0;
      end else begin
         if (hb_clr_s) begin
            hb_cnt_r <= 32'h0000_0000;
         end else if (hb_cnt_r != HB_TIMEOUT) begin
            hb_cnt_r <= hb_cnt_r + 32'h0000_0001;
         end
         HB_TIMEOUT_OUT <= (hb_cnt_r == HB_TIMEOUT);
      end
   end

   // Sticky interrupt; a set in the same cycle as a clear wins.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         IRQ_OUT <= 1'b0;
      end else if (irq_set_s) begin
         IRQ_OUT <= 1'b1;
      end else if (IRQ_CLR_IN) begin
         IRQ_OUT <= 1'b0;
      end
   end

`ifdef EVR_EVENT_COUNTER_EN
   // Mapped-event counter: every non-empty word reaching S2 counts once.
   always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
      if (!RESET_N_IN) begin
         EVENT_CNT_OUT <= 32'h0000_0000;
      end else if (word_s != 16'h0000) begin
         EVENT_CNT_OUT <= EVENT_CNT_OUT + 32'h0000_0001;
      end
   end
`else
   assign EVENT_CNT_OUT = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_evr_event_mapper.sv
// Directed bench for evr_event_mapper with a 1-clock-latency mapping RAM model.
module tb_evr_event_mapper;

   localparam int          NP  = 8;
   localparam int          PW  = 4;
   localparam logic [31:0] HBT = 32'd20;

   logic          CLK_IN = 1'b0;
   logic          RESET_N_IN = 1'b0;
   logic          MAP_EN_IN = 1'b1;
   logic [7:0]    EVENT_CODE_IN = 8'h00;
   logic          EVENT_VALID_IN = 1'b0;
   logic [7:0]    RD_ADDR_OUT;
   logic [15:0]   RD_DATA_IN;
   logic [NP-1:0] PULSE_OUT;
   logic [31:0]   TS_OUT;
   logic [31:0]   TS_LATCH_OUT;
   logic          TS_LATCH_VALID_OUT;
   logic          HB_TIMEOUT_OUT;
   logic          IRQ_OUT;
   logic          IRQ_CLR_IN = 1'b0;
   logic [31:0]   EVENT_CNT_OUT;

   logic [15:0]   mem [256];
   int            n_tests = 0;
   int            n_fail = 0;

   evr_event_mapper #(.NUM_PULSE(NP), .PULSE_WIDTH(PW), .HB_TIMEOUT(HBT)) dut (
      .CLK_IN(CLK_IN), .RESET_N_IN(RESET_N_IN), .MAP_EN_IN(MAP_EN_IN),
      .EVENT_CODE_IN(EVENT_CODE_IN), .EVENT_VALID_IN(EVENT_VALID_IN),
      .RD_ADDR_OUT(RD_ADDR_OUT), .RD_DATA_IN(RD_DATA_IN), .PULSE_OUT(PULSE_OUT),
      .TS_OUT(TS_OUT), .TS_LATCH_OUT(TS_LATCH_OUT), .TS_LATCH_VALID_OUT(TS_LATCH_VALID_OUT),
      .HB_TIMEOUT_OUT(HB_TIMEOUT_OUT), .IRQ_OUT(IRQ_OUT), .IRQ_CLR_IN(IRQ_CLR_IN),
      .EVENT_CNT_OUT(EVENT_CNT_OUT)
   );

   always #5 CLK_IN = ~CLK_IN;

   // Synchronous-read mapping RAM.
   always @(posedge CLK_IN) RD_DATA_IN <= mem[RD_ADDR_OUT];

   task automatic step();
      @(posedge CLK_IN);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Presents one event for one cycle; returns in cycle N+1.
   task automatic send(input logic [7:0] code);
      EVENT_CODE_IN  = code;
      EVENT_VALID_IN = 1'b1;
      step();
      EVENT_VALID_IN = 1'b0;
      EVENT_CODE_IN  = 8'h00;
   endtask

   task automatic test_reset();
      RESET_N_IN = 1'b0;
      idle(2);
      n_tests++;
      if (RD_ADDR_OUT !== 8'h00 || PULSE_OUT !== 8'h00) begin
         $display("FAIL reset_addr_pulse: got %h/%h expected 00/00", RD_ADDR_OUT, PULSE_OUT);
         n_fail++;
      end
      n_tests++;
      if (TS_OUT !== 32'h0 || TS_LATCH_OUT !== 32'h0) begin
         $display("FAIL reset_ts: got %h/%h expected 0/0", TS_OUT, TS_LATCH_OUT);
         n_fail++;
      end
      n_tests++;
      if ({TS_LATCH_VALID_OUT, HB_TIMEOUT_OUT, IRQ_OUT} !== 3'b000 || EVENT_CNT_OUT !== 32'h0) begin
         $display("FAIL reset_flags: got %b cnt %h expected 000 cnt 0",
                  {TS_LATCH_VALID_OUT, HB_TIMEOUT_OUT, IRQ_OUT}, EVENT_CNT_OUT);
         n_fail++;
      end
      #3;
      RESET_N_IN = 1'b1;
   endtask

   task automatic test_heartbeat();
      int k;
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (HB_TIMEOUT_OUT === 1'b1) begin
            k = i;
            break;
         end
      end
      n_tests++;
      if (k != 21) begin
         $display("FAIL hb_rise_cycle: got %0d expected 21", k);
         n_fail++;
      end
      mem[8'h10] = 16'h8000;
      send(8'h10);
      idle(2);
      n_tests++;
      if (HB_TIMEOUT_OUT !== 1'b1) begin
         $display("FAIL hb_at_clear: got %b expected 1", HB_TIMEOUT_OUT);
         n_fail++;
      end
      step();
      n_tests++;
      if (HB_TIMEOUT_OUT !== 1'b0) begin
         $display("FAIL hb_after_clear: got %b expected 0", HB_TIMEOUT_OUT);
         n_fail++;
      end
      idle(4);
   endtask

   task automatic test_pulse();
      mem[8'h7A] = 16'h0001;
      send(8'h7A);
      n_tests++;
      if (RD_ADDR_OUT !== 8'h7A || PULSE_OUT !== 8'h00) begin
         $display("FAIL pulse_n1: got addr %h pulse %h expected 7a 00", RD_ADDR_OUT, PULSE_OUT);
         n_fail++;
      end
      step();
      n_tests++;
      if (PULSE_OUT !== 8'h00) begin
         $display("FAIL pulse_n2: got %h expected 00", PULSE_OUT);
         n_fail++;
      end
      for (int j = 0; j < PW; j++) begin
         step();
         n_tests++;
         if (PULSE_OUT !== 8'h01 || IRQ_OUT !== 1'b0 || TS_LATCH_VALID_OUT !== 1'b0) begin
            $display("FAIL pulse_high_%0d: got pulse %h irq %b tsv %b expected 01 0 0",
                     j, PULSE_OUT, IRQ_OUT, TS_LATCH_VALID_OUT);
            n_fail++;
         end
      end
      step();
      n_tests++;
      if (PULSE_OUT !== 8'h00) begin
         $display("FAIL pulse_end: got %h expected 00", PULSE_OUT);
         n_fail++;
      end
      idle(3);
   endtask

   task automatic test_retrigger();
      send(8'h7A);
      step();
      send(8'h7A);
      for (int j = 0; j < 6; j++) begin
         n_tests++;
         if (PULSE_OUT !== 8'h01) begin
            $display("FAIL retrig_high_%0d: got %h expected 01", j, PULSE_OUT);
            n_fail++;
         end
         step();
      end
      n_tests++;
      if (PULSE_OUT !== 8'h00) begin
         $display("FAIL retrig_end: got %h expected 00", PULSE_OUT);
         n_fail++;
      end
      idle(3);
   endtask

   task automatic test_multi_bit();
      mem[8'h22] = 16'h0F81;
      send(8'h22);
      idle(2);
      n_tests++;
      if (PULSE_OUT !== 8'h81 || IRQ_OUT !== 1'b0 || TS_LATCH_VALID_OUT !== 1'b0) begin
         $display("FAIL multi_bit: got pulse %h irq %b tsv %b expected 81 0 0",
                  PULSE_OUT, IRQ_OUT, TS_LATCH_VALID_OUT);
         n_fail++;
      end
      idle(PW + 2);
   endtask

   task automatic test_irq();
      mem[8'h40] = 16'h4000;
      send(8'h40);
      step();
      n_tests++;
      if (IRQ_OUT !== 1'b0) begin
         $display("FAIL irq_n2: got %b expected 0", IRQ_OUT);
         n_fail++;
      end
      IRQ_CLR_IN = 1'b1;
      step();
      n_tests++;
      if (IRQ_OUT !== 1'b1) begin
         $display("FAIL irq_set_wins: got %b expected 1", IRQ_OUT);
         n_fail++;
      end
      step();
      IRQ_CLR_IN = 1'b0;
      n_tests++;
      if (IRQ_OUT !== 1'b0) begin
         $display("FAIL irq_clear: got %b expected 0", IRQ_OUT);
         n_fail++;
      end
      send(8'h40);
      idle(7);
      n_tests++;
      if (IRQ_OUT !== 1'b1) begin
         $display("FAIL irq_sticky: got %b expected 1", IRQ_OUT);
         n_fail++;
      end
      IRQ_CLR_IN = 1'b1;
      step();
      IRQ_CLR_IN = 1'b0;
      n_tests++;
      if (IRQ_OUT !== 1'b0) begin
         $display("FAIL irq_clear2: got %b expected 0", IRQ_OUT);
         n_fail++;
      end
   endtask

   task automatic test_ignored();
      mem[8'h60] = 16'h0000;
      mem[8'h00] = 16'h4001;
      send(8'h60);
      idle(4);
      send(8'h00);
      n_tests++;
      if (RD_ADDR_OUT !== 8'h60) begin
         $display("FAIL null_addr: got %h expected 60", RD_ADDR_OUT);
         n_fail++;
      end
      idle(3);
      n_tests++;
      if (PULSE_OUT !== 8'h00 || IRQ_OUT !== 1'b0) begin
         $display("FAIL null_action: got pulse %h irq %b expected 00 0", PULSE_OUT, IRQ_OUT);
         n_fail++;
      end
      MAP_EN_IN = 1'b0;
      send(8'h7A);
      n_tests++;
      if (RD_ADDR_OUT !== 8'h60) begin
         $display("FAIL disabled_addr: got %h expected 60", RD_ADDR_OUT);
         n_fail++;
      end
      idle(3);
      n_tests++;
      if (PULSE_OUT !== 8'h00) begin
         $display("FAIL disabled_action: got %h expected 00", PULSE_OUT);
         n_fail++;
      end
      MAP_EN_IN = 1'b1;
      send(8'h7A);
      MAP_EN_IN = 1'b0;
      idle(2);
      n_tests++;
      if (PULSE_OUT !== 8'h01 || RD_ADDR_OUT !== 8'h7A) begin
         $display("FAIL inflight_completes: got pulse %h addr %h expected 01 7a", PULSE_OUT, RD_ADDR_OUT);
         n_fail++;
      end
      MAP_EN_IN = 1'b1;
      idle(PW + 2);
   endtask

   task automatic test_timestamp();
      int guard;
      guard = 0;
      while (TS_OUT !== 32'h0000_1232 && guard < 20000) begin
         step();
         guard++;
      end
      n_tests++;
      if (guard >= 20000) begin
         $display("FAIL ts_wait: timestamp never reached 1232, got %h", TS_OUT);
         n_fail++;
      end
      mem[8'h30] = 16'h3000;
      mem[8'h31] = 16'h1000;
      send(8'h30);
      idle(2);
      n_tests++;
      if (TS_OUT !== 32'h0 || TS_LATCH_OUT !== 32'h1234 || TS_LATCH_VALID_OUT !== 1'b1) begin
         $display("FAIL ts_latch_reset: got ts %h latch %h v %b expected 0 1234 1",
                  TS_OUT, TS_LATCH_OUT, TS_LATCH_VALID_OUT);
         n_fail++;
      end
      step();
      n_tests++;
      if (TS_OUT !== 32'h1 || TS_LATCH_VALID_OUT !== 1'b0 || TS_LATCH_OUT !== 32'h1234) begin
         $display("FAIL ts_resume: got ts %h v %b latch %h expected 1 0 1234",
                  TS_OUT, TS_LATCH_VALID_OUT, TS_LATCH_OUT);
         n_fail++;
      end
      send(8'h31);
      idle(2);
      n_tests++;
      if (TS_LATCH_OUT !== 32'h3 || TS_LATCH_VALID_OUT !== 1'b1 || TS_OUT !== 32'h4) begin
         $display("FAIL ts_latch_only: got latch %h v %b ts %h expected 3 1 4",
                  TS_LATCH_OUT, TS_LATCH_VALID_OUT, TS_OUT);
         n_fail++;
      end
      idle(3);
   endtask

   task automatic test_reset_mid();
      send(8'h7A);
      step();
      RESET_N_IN = 1'b0;
      #1;
      n_tests++;
      if (RD_ADDR_OUT !== 8'h00 || TS_OUT !== 32'h0 || TS_LATCH_OUT !== 32'h0 || PULSE_OUT !== 8'h00) begin
         $display("FAIL reset_async: got addr %h ts %h latch %h pulse %h expected all 0",
                  RD_ADDR_OUT, TS_OUT, TS_LATCH_OUT, PULSE_OUT);
         n_fail++;
      end
      step();
      #3;
      RESET_N_IN = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         n_tests++;
         if (PULSE_OUT !== 8'h00) begin
            $display("FAIL reset_no_pulse_%0d: got %h expected 00", j, PULSE_OUT);
            n_fail++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_cnt;
      mem[8'h55] = 16'h0000;
      for (int j = 0; j < 5; j++) send(8'h7A);
      send(8'h55);
      for (int j = 0; j < 5; j++) begin
         n_tests++;
         if (PULSE_OUT !== 8'h01) begin
            $display("FAIL b2b_high_%0d: got %h expected 01", j, PULSE_OUT);
            n_fail++;
         end
         step();
      end
      n_tests++;
      if (PULSE_OUT !== 8'h00) begin
         $display("FAIL b2b_end: got %h expected 00", PULSE_OUT);
         n_fail++;
      end
`ifdef EVR_EVENT_COUNTER_EN
      exp_cnt = 32'd5;
`else
      exp_cnt = 32'd0;
`endif
      n_tests++;
      if (EVENT_CNT_OUT !== exp_cnt) begin
         $display("FAIL event_cnt: got %0d expected %0d", EVENT_CNT_OUT, exp_cnt);
         n_fail++;
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      test_reset();
      test_heartbeat();
      test_pulse();
      test_retrigger();
      test_multi_bit();
      test_irq();
      test_ignored();
      test_timestamp();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "bench timeout");
   end

endmodule
